// File: rtl/hbm_send_back_burst_if.sv
// Bus interfaces for the HBM write-back engine: the DMA write command channel
// and the DMA write data stream.
interface axis_mem_cmd;
    logic        valid;
    logic        ready;
    logic [63:0] address;
    logic [31:0] length;

    modport master (output valid, output address, output length, input ready);
    modport slave  (input valid, input address, input length, output ready);
endinterface

interface axi_stream #(
    parameter int DATA_W = 512
);
    logic                  valid;
    logic                  ready;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   keep;
    logic                  last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/hbm_send_back_burst.sv
// DMA write-back engine: buffers result beats in a FIFO and writes them to host
// memory as bursts of at most MAX_BURST bytes. Optional counters: SEND_BACK_STATS_EN.
module hbm_send_back_burst #(
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 512,
    parameter int AF_MARGIN  = 32,
    parameter int MAX_BURST  = 4096
) (
    input  logic                hbm_clk,
    input  logic                hbm_aresetn,
    axis_mem_cmd.master         m_axis_dma_write_cmd,
    axi_stream.master           m_axis_dma_write_data,
    input  logic                start,
    input  logic [63:0]         addr_x,
    input  logic [31:0]         data_length,
    input  logic [DATA_W-1:0]   back_data,
    input  logic                back_valid,
    output logic                almost_full,
    output logic                busy,
    output logic                done,
    output logic                overflow
`ifdef SEND_BACK_STATS_EN
    ,
    output logic [31:0]         stat_cmds,
    output logic [31:0]         stat_beats,
    output logic [31:0]         stat_stall
`endif
);

    localparam int           BYTES   = DATA_W / 8;
    localparam int           KW      = $clog2(BYTES);
    localparam int           AW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0]  MAX_B   = 32'(MAX_BURST);
    localparam logic [AW:0]  DEPTH_V = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]  AF_LVL  = (AW+1)'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [31:0] burst_of(input logic [31:0] rem);
        return (rem > MAX_B) ? MAX_B : rem;
    endfunction

    // Byte-enable for a beat holding r valid bytes; r == 0 means a full beat.
    function automatic logic [BYTES-1:0] keep_mask(input logic [KW-1:0] r);
        logic [BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (r == '0) || (i < int'(r));
        end
        return m;
    endfunction

    logic [1:0]        r_state;
    logic              r_in_v;
    logic [DATA_W-1:0] r_in_d;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wptr, r_rptr;
    logic              r_af, r_ovf;
    logic [63:0]       r_cur_addr;
    logic [31:0]       r_remaining, r_burst, r_beats, r_beat_cnt;
    logic              r_dv, r_dl;
    logic [DATA_W-1:0] r_dd;
    logic [BYTES-1:0]  r_dk;

    logic [AW:0]       w_level;
    logic              w_full, w_empty, w_wr;
    logic              w_cmd_hs, w_dat_hs, w_last_hs, w_pop, w_pop_last;
    logic [31:0]       w_rem_next;

    assign w_level    = r_wptr - r_rptr;
    assign w_full     = (w_level == DEPTH_V);
    assign w_empty    = (w_level == '0);
    assign w_wr       = r_in_v && !w_full;
    assign w_cmd_hs   = (r_state == S_CMD) && m_axis_dma_write_cmd.ready;
    assign w_dat_hs   = r_dv && m_axis_dma_write_data.ready;
    assign w_last_hs  = w_dat_hs && r_dl;
    assign w_pop      = (r_state == S_DATA) && !w_empty && (!r_dv || m_axis_dma_write_data.ready)
                        && (r_beat_cnt != r_beats);
    assign w_pop_last = ((r_beat_cnt + 32'd1) == r_beats);
    assign w_rem_next = r_remaining - r_burst;

    // Input staging register, FIFO pointers and status flags.
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_in_v <= 1'b0;
            r_in_d <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_af   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_in_v <= back_valid;
            r_in_d <= back_data;
            if (w_wr)   r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_af <= (w_level >= AF_LVL);
            if (r_in_v && w_full) r_ovf <= 1'b1;
        end
    end

    // FIFO storage has no reset; the pointers define what is valid.
    always_ff @(posedge hbm_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_in_d;
    end

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_burst     <= '0;
            r_beats     <= '0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_addr  <= addr_x;
                        r_remaining <= data_length;
                        r_burst     <= burst_of(data_length);
                        r_state     <= (data_length == 32'd0) ? S_DONE : S_CMD;
                    end
                end
                S_CMD: begin
                    if (w_cmd_hs) begin
                        r_beats    <= (r_burst + 32'(BYTES - 1)) >> KW;
                        r_beat_cnt <= 32'd0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_pop) r_beat_cnt <= r_beat_cnt + 32'd1;
                    if (w_last_hs) begin
                        r_remaining <= w_rem_next;
                        r_cur_addr  <= r_cur_addr + {32'd0, r_burst};
                        r_burst     <= burst_of(w_rem_next);
                        r_state     <= (w_rem_next == 32'd0) ? S_DONE : S_CMD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Only the final burst can be a non-multiple of the beat size, so its low bits give the tail.
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_dv <= 1'b0;
            r_dd <= '0;
            r_dk <= '0;
            r_dl <= 1'b0;
        end else if (w_pop) begin
            r_dv <= 1'b1;
            r_dd <= r_mem[r_rptr[AW-1:0]];
            r_dk <= w_pop_last ? keep_mask(r_burst[KW-1:0]) : {BYTES{1'b1}};
            r_dl <= w_pop_last;
        end else if (w_dat_hs) begin
            r_dv <= 1'b0;
            r_dl <= 1'b0;
        end
    end

    assign m_axis_dma_write_cmd.valid   = (r_state == S_CMD);
    assign m_axis_dma_write_cmd.address = r_cur_addr;
    assign m_axis_dma_write_cmd.length  = r_burst;
    assign m_axis_dma_write_data.valid  = r_dv;
    assign m_axis_dma_write_data.data   = r_dd;
    assign m_axis_dma_write_data.keep   = r_dk;
    assign m_axis_dma_write_data.last   = r_dl;
    assign almost_full = r_af;
    assign overflow    = r_ovf;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

`ifdef SEND_BACK_STATS_EN
    logic [31:0] r_stat_cmds, r_stat_beats, r_stat_stall;

    // Saturating activity counters, kept across transfers.
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_stat_cmds  <= '0;
            r_stat_beats <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_cmd_hs && (r_stat_cmds != 32'hFFFF_FFFF))  r_stat_cmds  <= r_stat_cmds + 32'd1;
            if (w_dat_hs && (r_stat_beats != 32'hFFFF_FFFF)) r_stat_beats <= r_stat_beats + 32'd1;
            if ((r_state == S_DATA) && w_empty && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_cmds  = r_stat_cmds;
    assign stat_beats = r_stat_beats;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_hbm_send_back_burst.sv
// Scoreboard bench for hbm_send_back_burst: expected commands, beats and data
// are queued at stimulus time and consumed by an independent monitor.
module tb_hbm_send_back_burst;

    localparam int DW    = 512;
    localparam int BY    = DW / 8;
    localparam int DEPTH = 512;
    localparam int MAXB  = 4096;

    logic          hbm_clk = 1'b0;
    logic          hbm_aresetn = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   addr_x = '0;
    logic [31:0]   data_length = '0;
    logic [DW-1:0] back_data = '0;
    logic          back_valid = 1'b0;
    logic          almost_full, busy, done, overflow;

    always #5 hbm_clk = ~hbm_clk;

    axis_mem_cmd cmd_if ();
    axi_stream #(.DATA_W(DW)) dat_if ();

    hbm_send_back_burst #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .AF_MARGIN(32), .MAX_BURST(MAXB)
    ) dut (
        .hbm_clk(hbm_clk), .hbm_aresetn(hbm_aresetn),
        .m_axis_dma_write_cmd(cmd_if), .m_axis_dma_write_data(dat_if),
        .start(start), .addr_x(addr_x), .data_length(data_length),
        .back_data(back_data), .back_valid(back_valid),
        .almost_full(almost_full), .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct { logic [63:0] addr; logic [31:0] len; } cmd_t;
    typedef struct { logic [BY-1:0] keep; logic last; logic fin; } beat_t;

    cmd_t          cmd_q [$];
    beat_t         beat_q[$];
    logic [DW-1:0] fifo_q[$];

    int  n_total = 0;
    int  n_bad   = 0;
    int  beats_seen = 0;
    bit  model_busy = 0, exp_done = 0, mon_en = 0, rand_rdy = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Ready generators for both downstream channels.
    initial begin
        cmd_if.ready = 1'b1;
        dat_if.ready = 1'b1;
        forever begin
            @(posedge hbm_clk); #1;
            cmd_if.ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            dat_if.ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: handshakes, stall stability, done/busy timing.
    logic          c_stall = 1'b0, d_stall = 1'b0;
    logic [63:0]   c_a;
    logic [31:0]   c_l;
    logic [DW-1:0] d_d, exp_d;
    logic [BY-1:0] d_k;
    logic          d_l;
    cmd_t          mc;
    beat_t         mb;
    initial begin
        forever begin
            @(negedge hbm_clk);
            if (mon_en) begin
                chk("done", done, exp_done);
                chk("busy", busy, model_busy);
                if (exp_done) begin
                    exp_done   = 0;
                    model_busy = 0;
                end
                if (c_stall) begin
                    chk("cmd_hold_valid", cmd_if.valid, 1'b1);
                    chk("cmd_hold_addr", cmd_if.address, c_a);
                    chk("cmd_hold_len", cmd_if.length, c_l);
                end
                if (d_stall) begin
                    chk("dat_hold_valid", dat_if.valid, 1'b1);
                    chk("dat_hold_data", dat_if.data, d_d);
                    chk("dat_hold_keep", dat_if.keep, d_k);
                    chk("dat_hold_last", dat_if.last, d_l);
                end
                c_stall = cmd_if.valid && !cmd_if.ready;
                c_a = cmd_if.address; c_l = cmd_if.length;
                d_stall = dat_if.valid && !dat_if.ready;
                d_d = dat_if.data; d_k = dat_if.keep; d_l = dat_if.last;
                if (cmd_if.valid && cmd_if.ready) begin
                    chk("cmd_expected", cmd_q.size() != 0, 1'b1);
                    if (cmd_q.size() != 0) begin
                        mc = cmd_q.pop_front();
                        chk("cmd_addr", cmd_if.address, mc.addr);
                        chk("cmd_len", cmd_if.length, mc.len);
                    end
                end
                if (dat_if.valid && dat_if.ready) begin
                    beats_seen++;
                    chk("beat_expected", (beat_q.size() != 0) && (fifo_q.size() != 0), 1'b1);
                    if ((beat_q.size() != 0) && (fifo_q.size() != 0)) begin
                        mb    = beat_q.pop_front();
                        exp_d = fifo_q.pop_front();
                        chk("beat_data", dat_if.data, exp_d);
                        chk("beat_keep", dat_if.keep, mb.keep);
                        chk("beat_last", dat_if.last, mb.last);
                        if (mb.fin) exp_done = 1;
                    end
                end
            end
        end
    end

    task automatic push_beats(input int n, input int gap);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = rnd_beat();
            back_data  = v;
            back_valid = 1'b1;
            if (fifo_q.size() < DEPTH) fifo_q.push_back(v);
            @(posedge hbm_clk); #1;
            back_valid = 1'b0;
            if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge hbm_clk); #1; end
        end
    endtask

    task automatic do_start(input logic [63:0] a, input logic [31:0] len);
        logic [31:0] rem, b, nb, r;
        logic [63:0] ca;
        cmd_t  c;
        beat_t bt;
        rem = len; ca = a; r = len % BY;
        while (rem != 0) begin
            b = (rem > MAXB) ? MAXB : rem;
            c.addr = ca; c.len = b;
            cmd_q.push_back(c);
            nb = (b + BY - 1) / BY;
            for (int k = 1; k <= int'(nb); k++) begin
                bt.last = (k == int'(nb));
                bt.fin  = bt.last && (rem == b);
                bt.keep = (bt.fin && r != 0) ? ((64'd1 << r) - 64'd1) : {BY{1'b1}};
                beat_q.push_back(bt);
            end
            rem = rem - b;
            ca  = ca + {32'd0, b};
        end
        start = 1'b1; addr_x = a; data_length = len;
        @(posedge hbm_clk); #1;
        start = 1'b0;
        model_busy = 1;
        if (len == 0) exp_done = 1;
        else chk("cmd_valid_after_start", cmd_if.valid, 1'b1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (model_busy && n < budget) begin @(posedge hbm_clk); #1; n++; end
        chk({nm, "_completed"}, model_busy, 1'b0);
        chk({nm, "_cmds_left"}, cmd_q.size(), 0);
        chk({nm, "_beats_left"}, beat_q.size(), 0);
        chk({nm, "_data_left"}, fifo_q.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_cmd_valid"}, cmd_if.valid, 1'b0);
        chk({nm, "_cmd_addr"}, cmd_if.address, 64'd0);
        chk({nm, "_cmd_len"}, cmd_if.length, 32'd0);
        chk({nm, "_dat_valid"}, dat_if.valid, 1'b0);
        chk({nm, "_dat_data"}, dat_if.data, '0);
        chk({nm, "_dat_keep"}, dat_if.keep, '0);
        chk({nm, "_dat_last"}, dat_if.last, 1'b0);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_done"}, done, 1'b0);
        chk({nm, "_overflow"}, overflow, 1'b0);
        chk({nm, "_almost_full"}, almost_full, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base, n, len, nb, k;
    initial begin
        repeat (3) @(posedge hbm_clk);
        @(negedge hbm_clk);
        chk_zero("reset");
        @(posedge hbm_clk); #1;
        hbm_aresetn = 1'b1;
        mon_en = 1;

        // Single 256-byte burst from preloaded data.
        push_beats(4, 0);
        repeat (3) begin @(posedge hbm_clk); #1; end
        do_start(64'h1000, 32'd256);
        wait_idle("basic", 200);

        // Three bursts with a partial tail beat.
        push_beats(157, 0);
        do_start(64'h0000_0002_0000_0040, 32'd10000);
        wait_idle("split", 1000);

        // Address wraps past 2^64 between bursts.
        push_beats(128, 0);
        do_start(64'hFFFF_FFFF_FFFF_F000, 32'd8192);
        wait_idle("wrap", 1000);

        // Zero-length transfer.
        do_start(64'h40, 32'd0);
        wait_idle("zero", 20);

        // Random lengths, random backpressure, data trickling in, ignored restart.
        rand_rdy = 1;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 150 * BY);
            nb  = (len + BY - 1) / BY;
            k   = $urandom_range(0, nb);
            push_beats(k, 0);
            do_start({$urandom(), $urandom()} & ~64'h3F, len);
            start = 1'b1; addr_x = {$urandom(), $urandom()}; data_length = $urandom_range(1, 5000);
            @(posedge hbm_clk); #1;
            start = 1'b0;
            push_beats(nb - k, 3);
            wait_idle("random", 5000);
        end
        rand_rdy = 0;
        repeat (2) begin @(posedge hbm_clk); #1; end

        // Fill without start: almost_full threshold and overflow.
        push_beats(479, 0);
        repeat (4) begin @(posedge hbm_clk); #1; end
        chk("af_at_479", almost_full, 1'b0);
        push_beats(1, 0);
        repeat (4) begin @(posedge hbm_clk); #1; end
        chk("af_at_480", almost_full, 1'b1);
        push_beats(32, 0);
        repeat (4) begin @(posedge hbm_clk); #1; end
        chk("ovf_at_512", overflow, 1'b0);
        push_beats(1, 0);
        repeat (4) begin @(posedge hbm_clk); #1; end
        chk("ovf_at_513", overflow, 1'b1);
        do_start(64'h8000, 32'd32768);
        wait_idle("drain", 3000);
        chk("ovf_sticky", overflow, 1'b1);
        chk("af_after_drain", almost_full, 1'b0);

        // Reset in the middle of a 64-beat burst.
        push_beats(64, 0);
        base = beats_seen;
        do_start(64'h9000, 32'd4096);
        n = 0;
        while (beats_seen < base + 10 && n < 200) begin @(posedge hbm_clk); #1; n++; end
        chk("mid_reset_progress", beats_seen >= base + 10, 1'b1);
        mon_en = 0;
        hbm_aresetn = 1'b0;
        cmd_q.delete(); beat_q.delete(); fifo_q.delete();
        model_busy = 0; exp_done = 0; c_stall = 1'b0; d_stall = 1'b0;
        @(negedge hbm_clk);
        chk_zero("mid_reset");
        @(posedge hbm_clk); #1;
        hbm_aresetn = 1'b1;
        mon_en = 1;

        // FIFO must be empty after reset; then input-to-output latency.
        do_start(64'hA000, 32'd256);
        repeat (10) begin
            @(negedge hbm_clk);
            chk("no_stale_beat", dat_if.valid, 1'b0);
        end
        @(posedge hbm_clk); #1;
        push_beats(1, 0);
        @(negedge hbm_clk); chk("lat_t1", dat_if.valid, 1'b0);
        @(negedge hbm_clk); chk("lat_t2", dat_if.valid, 1'b0);
        @(negedge hbm_clk); chk("lat_t3", dat_if.valid, 1'b1);
        @(posedge hbm_clk); #1;
        push_beats(3, 0);
        wait_idle("after_reset", 200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
